// File: rtl/frame_check_rx.sv
// Serial frame receiver: DATA_W payload bits then CRC_W check bits, MSB first,
// CRC-8 (poly 0x07, init 0) over the payload, one-entry output buffer plus stats.
module frame_check_rx #(
  parameter int DATA_W = 14,
  parameter int CRC_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdi,
  input  logic              sdi_vld,
  input  logic              sof,
  input  logic              clr_stat,
  input  logic              out_rdy,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  output logic              out_crc_ok,
  output logic [7:0]        frame_cnt,
  output logic [7:0]        err_cnt,
  output logic              ovf,
  output logic              abort
);

  localparam int CNT_W = $clog2(DATA_W > CRC_W ? DATA_W : CRC_W) + 1;
  localparam logic [CRC_W-1:0] POLY = CRC_W'(8'h07);

  typedef enum logic [1:0] {IDLE, DATA, CHK} state_t;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                input logic bit_in);
    logic fb;
    fb = crc[CRC_W-1] ^ bit_in;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   payload_q, payload_d;
  logic [CRC_W-1:0]    chk_q, chk_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic                out_vld_q, out_vld_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_crc_ok_q, out_crc_ok_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                ovf_q, ovf_d;
  logic                abort_q, abort_d;
  logic                done;
  logic                restart;
  logic                pop;
  logic                rx_ok;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    payload_d = payload_q;
    chk_d     = chk_q;
    crc_d     = crc_q;
    done      = 1'b0;
    restart   = 1'b0;
    if (sdi_vld) begin
      if (sof) begin
        // sof always wins: a frame in progress is thrown away and this bit starts a new one
        restart   = (state_q != IDLE);
        state_d   = DATA;
        cnt_d     = CNT_W'(1);
        payload_d = {{(DATA_W-1){1'b0}}, sdi};
        chk_d     = '0;
        crc_d     = crc_step('0, sdi);
      end else begin
        case (state_q)
          DATA: begin
            payload_d = {payload_q[DATA_W-2:0], sdi};
            crc_d     = crc_step(crc_q, sdi);
            if (cnt_q == CNT_W'(DATA_W-1)) begin
              state_d = CHK;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          CHK: begin
            chk_d = {chk_q[CRC_W-2:0], sdi};
            if (cnt_q == CNT_W'(CRC_W-1)) begin
              state_d = IDLE;
              cnt_d   = '0;
              done    = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    pop          = out_vld_q && out_rdy;
    rx_ok        = ({chk_q[CRC_W-2:0], sdi} == crc_q);
    out_vld_d    = out_vld_q && !pop;
    out_data_d   = out_data_q;
    out_crc_ok_d = out_crc_ok_q;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;
    ovf_d        = ovf_q;
    abort_d      = abort_q || restart;
    if (done) begin
      if (!out_vld_q || pop) begin
        out_vld_d    = 1'b1;
        out_data_d   = payload_q;
        out_crc_ok_d = rx_ok;
        frame_cnt_d  = frame_cnt_q + 8'd1;
        if (!rx_ok) err_cnt_d = sat_inc(err_cnt_q);
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (clr_stat) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
      ovf_d       = 1'b0;
      abort_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      payload_q    <= '0;
      chk_q        <= '0;
      crc_q        <= '0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      out_crc_ok_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
      ovf_q        <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      payload_q    <= payload_d;
      chk_q        <= chk_d;
      crc_q        <= crc_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_crc_ok_q <= out_crc_ok_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
      ovf_q        <= ovf_d;
      abort_q      <= abort_d;
    end
  end

  assign out_vld    = out_vld_q;
  assign out_data   = out_data_q;
  assign out_crc_ok = out_crc_ok_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign ovf        = ovf_q;
  assign abort      = abort_q;

endmodule

// File: tb/tb_frame_check_rx.sv
// Bench for frame_check_rx: frame-level reference model feeding a scoreboard,
// with a negedge monitor comparing every presented entry and the status outputs.
module tb_frame_check_rx;
  localparam int DATA_W = 14;
  localparam int CRC_W  = 8;
  localparam int FRM    = DATA_W + CRC_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sdi = 1'b0;
  logic              sdi_vld = 1'b0;
  logic              sof = 1'b0;
  logic              clr_stat = 1'b0;
  logic              out_rdy = 1'b1;
  logic              out_vld;
  logic [DATA_W-1:0] out_data;
  logic              out_crc_ok;
  logic [7:0]        frame_cnt;
  logic [7:0]        err_cnt;
  logic              ovf;
  logic              abort;

  frame_check_rx #(.DATA_W(DATA_W), .CRC_W(CRC_W)) dut (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .sdi_vld(sdi_vld), .sof(sof),
    .clr_stat(clr_stat), .out_rdy(out_rdy), .out_vld(out_vld),
    .out_data(out_data), .out_crc_ok(out_crc_ok), .frame_cnt(frame_cnt),
    .err_cnt(err_cnt), .ovf(ovf), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              ok;
  } exp_t;

  exp_t       sbq[$];
  int         errors = 0;
  int         checks = 0;
  bit         mon_en = 1'b0;
  bit         rnd_rdy = 1'b0;
  bit         in_frame = 1'b0;
  bit         m_full = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_abort = 1'b0;
  logic [7:0] m_fcnt = '0;
  logic [7:0] m_ecnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Remainder of payload*x^8 divided by x^8+x^2+x+1
  function automatic logic [7:0] ref_crc(input logic [DATA_W-1:0] p);
    logic [DATA_W+7:0] r;
    logic [DATA_W+7:0] g;
    r = {p, 8'h00};
    g = {{(DATA_W-1){1'b0}}, 9'h107};
    for (int k = DATA_W + 7; k >= 8; k--)
      if (r[k]) r = r ^ (g << (k - 8));
    return r[7:0];
  endfunction

  // One clock edge: frame-level model of the output entry and statistics
  task automatic tick(input bit comp, input bit abt, input logic [DATA_W-1:0] p,
                      input logic [7:0] c);
    bit ok;
    @(posedge clk);
    if (!rst_n) begin
      m_full = 1'b0; m_ovf = 1'b0; m_abort = 1'b0; m_fcnt = '0; m_ecnt = '0;
      sbq.delete();
    end else begin
      if (m_full && out_rdy) m_full = 1'b0;
      if (comp) begin
        ok = (c == ref_crc(p));
        if (!m_full) begin
          sbq.push_back({p, ok});
          m_full = 1'b1;
          m_fcnt = m_fcnt + 8'd1;
          if (!ok && m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (abt) m_abort = 1'b1;
      if (clr_stat) begin
        m_fcnt = '0; m_ecnt = '0; m_ovf = 1'b0; m_abort = 1'b0;
      end
    end
    #1;
  endtask

  task automatic drive_rdy();
    if (rnd_rdy) out_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sdi_vld = 1'b0; sdi = 1'($urandom); sof = 1'($urandom);
      drive_rdy();
      tick(1'b0, 1'b0, '0, '0);
    end
    sof = 1'b0;
  endtask

  // gap: 0 contiguous, 1 idle between every bit, 2 random idles
  task automatic send_frame(input logic [DATA_W-1:0] p, input logic [7:0] c,
                            input int gap, input int nbits);
    logic [FRM-1:0] w;
    bit abt;
    w = {p, c};
    for (int i = 0; i < nbits; i++) begin
      if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 2) == 0)) idle(1);
      sdi_vld = 1'b1; sdi = w[FRM-1-i]; sof = (i == 0);
      drive_rdy();
      abt = (i == 0) && in_frame;
      if (i == 0) in_frame = 1'b1;
      if (i == FRM - 1) in_frame = 1'b0;
      tick(i == FRM - 1, abt, p, c);
    end
    sdi_vld = 1'b0; sof = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_stat = 1'b1;
    tick(1'b0, 1'b0, '0, '0);
    clr_stat = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("status", 32'({out_vld, ovf, abort, frame_cnt, err_cnt}),
          32'({m_full, m_ovf, m_abort, m_fcnt, m_ecnt}));
      if (out_vld) begin
        chk("entry_expected", 32'(sbq.size() > 0), 32'd1);
        if (sbq.size() > 0) begin
          chk("out_data", 32'(out_data), 32'(sbq[0].data));
          chk("out_crc_ok", 32'(out_crc_ok), 32'(sbq[0].ok));
          if (out_rdy) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DATA_W-1:0] p;
    logic [7:0]        c;
    int                n;

    rst_n = 1'b0;
    tick(1'b0, 1'b0, '0, '0);
    tick(1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_stats", 32'({frame_cnt, err_cnt, ovf, abort, out_crc_ok}), 32'd0);
    mon_en = 1'b1;

    out_rdy = 1'b1;
    send_frame(14'h0001, 8'h07, 0, FRM);
    chk("t1_out_vld", 32'(out_vld), 32'd1);
    chk("t1_out_data", 32'(out_data), 32'h0001);
    chk("t1_crc_ok", 32'(out_crc_ok), 32'd1);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_err_cnt", 32'(err_cnt), 32'd0);
    idle(2);

    send_frame(14'h0002, 8'h0F, 0, FRM);
    chk("t2_crc_ok", 32'(out_crc_ok), 32'd0);
    chk("t2_err_cnt", 32'(err_cnt), 32'd1);
    idle(2);

    pulse_clr();
    out_rdy = 1'b0;
    send_frame(14'h0003, ref_crc(14'h0003), 0, FRM);
    chk("t3_first_data", 32'(out_data), 32'h0003);
    send_frame(14'h0005, ref_crc(14'h0005), 0, FRM);
    chk("t3_held_data", 32'(out_data), 32'h0003);
    chk("t3_ovf", 32'(ovf), 32'd1);
    chk("t3_frame_cnt", 32'(frame_cnt), 32'd1);
    idle(3);
    out_rdy = 1'b1;
    idle(2);
    chk("t3_drained", 32'(out_vld), 32'd0);

    pulse_clr();
    send_frame(14'h3ABC, 8'h55, 0, 8);
    send_frame(14'h0000, 8'h00, 0, FRM);
    chk("t4_abort", 32'(abort), 32'd1);
    chk("t4_out_vld", 32'(out_vld), 32'd1);
    chk("t4_crc_ok", 32'(out_crc_ok), 32'd1);
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd1);
    idle(2);

    send_frame(14'h2AB5, ref_crc(14'h2AB5), 1, FRM);
    chk("t5_out_vld", 32'(out_vld), 32'd1);
    chk("t5_out_data", 32'(out_data), 32'h2AB5);
    chk("t5_crc_ok", 32'(out_crc_ok), 32'd1);
    idle(2);

    pulse_clr();
    for (int i = 0; i < 256; i++) begin
      p = DATA_W'($urandom);
      send_frame(p, ref_crc(p) ^ 8'h01, 0, FRM);
    end
    idle(1);
    chk("t6_err_sat", 32'(err_cnt), 32'd255);
    chk("t6_frame_wrap", 32'(frame_cnt), 32'd0);
    pulse_clr();
    chk("t6_err_clr", 32'(err_cnt), 32'd0);

    p = 14'h1234;
    send_frame(p, ref_crc(p), 0, DATA_W + 4);
    rst_n = 1'b0;
    tick(1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    in_frame = 1'b0;
    idle(30);
    chk("t7_no_vld_after_rst", 32'(out_vld), 32'd0);
    for (int i = 0; i < FRM; i++) begin
      sdi_vld = 1'b1; sdi = 1'($urandom); sof = 1'b0;
      tick(1'b0, 1'b0, '0, '0);
    end
    sdi_vld = 1'b0;
    idle(3);
    chk("t7_needs_sof", 32'(frame_cnt), 32'd0);

    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      p = DATA_W'($urandom);
      c = ($urandom_range(0, 2) == 0) ? 8'($urandom) : ref_crc(p);
      n = ($urandom_range(0, 5) == 0) ? $urandom_range(1, FRM - 1) : FRM;
      send_frame(p, c, 2, n);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      if ($urandom_range(0, 19) == 0) pulse_clr();
    end
    rnd_rdy = 1'b0;
    out_rdy = 1'b1;
    idle(4);
    chk("final_queue_empty", 32'(sbq.size()), 32'd0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_check_rx.md
FRAME_CHECK_RX -- requirements
Module: frame_check_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 14, payload bits per frame.
REQ-002 The block SHALL have parameter CRC_W, default 8, check bits per frame; the polynomial is fixed at x^8+x^2+x+1 (0x07).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port sdi  input  1  serial data bit, MSB first.
REQ-006 The block SHALL have port sdi_vld  input  1  sdi holds a valid bit this cycle.
REQ-007 The block SHALL have port sof  input  1  start of frame, qualified by sdi_vld, coincident with the first payload bit.
REQ-008 The block SHALL have port clr_stat  input  1  clears the counters and the sticky flags.
REQ-009 The block SHALL have port out_rdy  input  1  downstream accepts the output entry.
REQ-010 The block SHALL have port out_vld  output  1  the output entry is valid.
REQ-011 The block SHALL have port out_data  output  DATA_W  received payload.
REQ-012 The block SHALL have port out_crc_ok  output  1  received check equals the computed CRC.
REQ-013 The block SHALL have port frame_cnt  output  8  count of frames written to the output entry; wraps.
REQ-014 The block SHALL have port err_cnt  output  8  count of CRC-failed frames; saturates at 255.
REQ-015 The block SHALL have port ovf  output  1  sticky: a completed frame was dropped.
REQ-016 The block SHALL have port abort  output  1  sticky: a frame was restarted by sof mid-frame.

Function
REQ-017 The FSM SHALL have three states: IDLE, DATA and CHK.
REQ-018 In IDLE, a cycle with sdi_vld=1 and sof=0 SHALL be ignored.
REQ-019 In IDLE, sdi_vld=1 with sof=1 SHALL clear the CRC register to 0x00, shift in bit 1 and go to DATA.
REQ-020 In DATA, each valid bit SHALL be shifted into the payload register and update the CRC: fb=crc[7]^sdi; crc={crc[6:0],1'b0}^(fb?0x07:0x00).
REQ-021 After payload bit DATA_W is accepted, the FSM SHALL go to CHK.
REQ-022 In CHK, CRC_W valid bits SHALL be shifted into the check register, MSB first.
REQ-023 After the last check bit, the FSM SHALL return to IDLE.
REQ-024 Cycles with sdi_vld=0 SHALL leave all state and bit counters unchanged, in any state.
REQ-025 sof=1 with sdi_vld=1 in DATA or CHK SHALL discard the partial frame, set abort, and treat that bit as bit 1 of a new frame (state DATA).
REQ-026 On the cycle after the last check bit, when the output entry is empty or being popped that cycle, out_vld SHALL be 1, out_data SHALL be the payload, out_crc_ok SHALL be (received check == computed CRC), and frame_cnt SHALL increment by 1.
REQ-027 The output entry SHALL pop on out_vld && out_rdy.
REQ-028 A simultaneous pop and frame completion SHALL refill the entry, with no ovf and no bubble.
REQ-029 When the output entry is full and not popping at frame completion, the new frame SHALL be dropped, ovf set, and frame_cnt and err_cnt left unchanged.
REQ-030 err_cnt SHALL increment only for frames written with out_crc_ok=0, and SHALL saturate at 255.
REQ-031 out_data and out_crc_ok SHALL stay stable while out_vld=1 and out_rdy=0.
REQ-032 clr_stat SHALL clear frame_cnt, err_cnt, ovf and abort to 0; clr_stat takes priority over any increment in the same cycle.

Reset
REQ-033 While rst_n=0 at a clock edge, the block SHALL set FSM=IDLE, bit counter, payload, check and CRC registers =0, out_vld=0, out_data=0, out_crc_ok=0, frame_cnt=0, err_cnt=0, ovf=0, abort=0.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame and any held output entry with no out_vld pulse.
REQ-035 After reset, the block SHALL require a new sof.

Verification
REQ-036 The bench SHALL cover: payload 0x0001, check 0x07, out_rdy=1 -> out_vld=1 one cycle after the last bit, out_data=0x0001, out_crc_ok=1, frame_cnt=1, err_cnt=0.
REQ-037 The bench SHALL cover: payload 0x0002, check 0x0F -> out_crc_ok=0, err_cnt=1 (correct check is 0x0E).
REQ-038 The bench SHALL cover: out_rdy=0, two back-to-back valid frames -> first held unchanged, ovf=1, frame_cnt=1.
REQ-039 The bench SHALL cover: sof at payload bit 9, then a full 22-bit frame with payload 0x0000 and check 0x00 -> abort=1, one output, out_crc_ok=1.
REQ-040 The bench SHALL cover: sdi_vld low on alternate cycles across a frame -> same output as the contiguous frame, one cycle after the last valid bit.
REQ-041 The bench SHALL cover: 256 bad frames, then clr_stat -> err_cnt=255 before clr_stat, 0 after; rst_n=0 at check bit 4 -> out_vld stays 0.
